// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// funct3 access codes, the SEXT sign-extension macro and small decode helpers.
// Ports: none (package).

`ifndef SEXT
// Sign-extend the low w bits of v to 64 bits.
`define SEXT(v, w) {{(64-(w)){v[(w)-1]}}, v[(w)-1:0]}
`endif

package mem_stage_pkg;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_WAIT_R = 1'b1
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // funct3[1:0] encodes the access size for every code, signed or not;
    // 111 falls onto 11 and therefore behaves as a doubleword.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: shifts the read doubleword down to the addressed byte
// and sign/zero-extends it according to funct3. Purely combinational.
// Ports: rdata (bus doubleword), off (byte offset), funct3 (size/sign), result.

module load_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (funct3)
            F3_B:    result = `SEXT(shifted, 8);
            F3_H:    result = `SEXT(shifted, 16);
            F3_W:    result = `SEXT(shifted, 32);
            F3_BU:   result = {56'b0, shifted[7:0]};
            F3_HU:   result = {48'b0, shifted[15:0]};
            F3_WU:   result = {32'b0, shifted[31:0]};
            default: result = shifted;   // LD and the unused 111 code
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and write-back.
// Latency: ALU/misaligned 1 cycle, store 1 + grant wait, load >= 2 cycles.
// Backpressure: stall_o holds execute while a bus request or load response is pending.
// Ports: clk/rst; execute-side valid_i, aluout_i, load_i, store_i, funct3_i,
// sdata_i, wen_i, rd_i, pc_i, exit_i, stall_o; bus mem_req_o, mem_we_o,
// mem_addr_o, mem_wstrb_o, mem_wdata_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i;
// write-back wb_valid_o, wb_wen_o, wb_rd_o, wb_data_o, wb_pc_o, wb_exit_o, misalign_o.

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [63:0] aluout_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] sdata_i,
    input  logic        wen_i,
    input  logic [4:0]  rd_i,
    input  logic [63:0] pc_i,
    input  logic        exit_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [7:0]  mem_wstrb_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_wen_o,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_data_o,
    output logic [63:0] wb_pc_o,
    output logic        wb_exit_o,
    output logic        misalign_o
);

    mem_state_e  state_q, state_d;

    // Load context captured at grant, used when the response returns.
    logic [2:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [63:0] pc_q, pc_d;
    logic        exit_q, exit_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_wen_q, wb_wen_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [63:0] wb_pc_q, wb_pc_d;
    logic        wb_exit_q, wb_exit_d;
    logic        misalign_q, misalign_d;

    logic [2:0]  off;
    logic        is_mem, mis, mem_go, load_grant;
    logic        req, we, done_idle, done_wait, stall;
    logic [7:0]  wstrb;
    logic [63:0] wdata, load_data;

    assign off    = aluout_i[2:0];
    assign is_mem = load_i | store_i;
    assign mis    = valid_i & is_mem & is_misaligned(funct3_i[1:0], off);
    assign mem_go = valid_i & is_mem & ~mis;

    load_align u_load_align (
        .rdata  (mem_rdata_i),
        .off    (off_q),
        .funct3 (f3_q),
        .result (load_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MEM_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE:   if (mem_go && load_i && mem_gnt_i) state_d = MEM_WAIT_R;
            MEM_WAIT_R: if (mem_rvalid_i)                  state_d = MEM_IDLE;
            default:    state_d = MEM_IDLE;
        endcase
    end

    // Output / completion logic
    always_comb begin
        req        = 1'b0;
        we         = 1'b0;
        wstrb      = 8'h00;
        wdata      = 64'h0;
        stall      = 1'b0;
        done_idle  = 1'b0;
        done_wait  = 1'b0;
        load_grant = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                req        = mem_go;
                we         = mem_go & store_i;
                if (mem_go && store_i) begin
                    wstrb = size_mask(funct3_i[1:0]) << off;
                    wdata = sdata_i << {off, 3'b000};
                end
                // A granted store finishes now; a granted load still has to wait.
                stall      = mem_go & ~(store_i & mem_gnt_i);
                load_grant = mem_go & load_i & mem_gnt_i;
                done_idle  = (valid_i & ~is_mem) | mis | (mem_go & store_i & mem_gnt_i);
            end
            MEM_WAIT_R: begin
                stall     = ~mem_rvalid_i;
                done_wait = mem_rvalid_i;
            end
            default: ;
        endcase
    end

    assign stall_o     = stall;
    assign mem_req_o   = req & ~rst;
    assign mem_we_o    = we & ~rst;
    assign mem_addr_o  = rst ? 64'h0 : {aluout_i[63:3], 3'b000};
    assign mem_wstrb_o = rst ? 8'h00 : wstrb;
    assign mem_wdata_o = rst ? 64'h0 : wdata;

    // Datapath next-state: load context and write-back registers
    always_comb begin
        off_d      = off_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        pc_d       = pc_q;
        exit_d     = exit_q;
        wb_valid_d = done_idle | done_wait;
        wb_wen_d   = wb_wen_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        wb_exit_d  = wb_exit_q;
        misalign_d = done_idle & mis;
        if (load_grant) begin
            off_d  = off;
            f3_d   = funct3_i;
            rd_d   = rd_i;
            wen_d  = wen_i;
            pc_d   = pc_i;
            exit_d = exit_i;
        end
        if (done_idle) begin
            wb_wen_d  = wen_i & ~mis;
            wb_rd_d   = rd_i;
            wb_data_d = aluout_i;
            wb_pc_d   = pc_i;
            wb_exit_d = exit_i;
        end else if (done_wait) begin
            wb_wen_d  = wen_q;
            wb_rd_d   = rd_q;
            wb_data_d = load_data;
            wb_pc_d   = pc_q;
            wb_exit_d = exit_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q      <= 3'b0;
            f3_q       <= 3'b0;
            rd_q       <= 5'b0;
            wen_q      <= 1'b0;
            pc_q       <= 64'h0;
            exit_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= 5'b0;
            wb_data_q  <= 64'h0;
            wb_pc_q    <= 64'h0;
            wb_exit_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            off_q      <= off_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            pc_q       <= pc_d;
            exit_q     <= exit_d;
            wb_valid_q <= wb_valid_d;
            wb_wen_q   <= wb_wen_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            wb_exit_q  <= wb_exit_d;
            misalign_q <= misalign_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_wen_o   = wb_wen_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign wb_pc_o    = wb_pc_q;
    assign wb_exit_o  = wb_exit_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU passthrough, stores with grant delay,
// signed/unsigned loads, misalignment, reset during a load, back-to-back loads.
// Ports: none (top-level bench).

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [63:0] aluout_i;
    logic        load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] sdata_i;
    logic        wen_i;
    logic [4:0]  rd_i;
    logic [63:0] pc_i;
    logic        exit_i;
    logic        stall_o;
    logic        mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o;
    logic [7:0]  mem_wstrb_o;
    logic [63:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        wb_valid_o, wb_wen_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o, wb_pc_o;
    logic        wb_exit_o, misalign_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .aluout_i     (aluout_i),
        .load_i       (load_i),
        .store_i      (store_i),
        .funct3_i     (funct3_i),
        .sdata_i      (sdata_i),
        .wen_i        (wen_i),
        .rd_i         (rd_i),
        .pc_i         (pc_i),
        .exit_i       (exit_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_wen_o     (wb_wen_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .wb_pc_o      (wb_pc_o),
        .wb_exit_o    (wb_exit_o),
        .misalign_o   (misalign_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid_i      = 1'b0;
        aluout_i     = 64'h0;
        load_i       = 1'b0;
        store_i      = 1'b0;
        funct3_i     = 3'b000;
        sdata_i      = 64'h0;
        wen_i        = 1'b0;
        rd_i         = 5'd0;
        pc_i         = 64'h0;
        exit_i       = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 64'h0;
    endtask

    initial begin
        // ---- reset, with a load presented to show bus outputs are forced low
        clr();
        rst = 1'b1;
        valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'b011; aluout_i = 64'h4000;
        tick(); tick();
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_addr", mem_addr_o, 64'h0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_wb_data", wb_data_o, 64'h0);
        chk("rst_misalign", misalign_o, 1'b0);
        rst = 1'b0;
        clr();
        #1;
        chk("idle_stall", stall_o, 1'b0);

        // ---- ADD passthrough
        valid_i = 1'b1; aluout_i = 64'h1234; wen_i = 1'b1; rd_i = 5'd5; pc_i = 64'h100;
        #1;
        chk("add_req", mem_req_o, 1'b0);
        chk("add_stall", stall_o, 1'b0);
        tick();
        chk("add_wb_valid", wb_valid_o, 1'b1);
        chk("add_wb_data", wb_data_o, 64'h1234);
        chk("add_wb_rd", wb_rd_o, 5'd5);
        chk("add_wb_wen", wb_wen_o, 1'b1);
        clr();
        tick();
        chk("add_wb_valid_drop", wb_valid_o, 1'b0);
        chk("add_wb_data_hold", wb_data_o, 64'h1234);

        // ---- SB 0x1003 with grant two cycles late
        valid_i = 1'b1; store_i = 1'b1; funct3_i = 3'b000; aluout_i = 64'h1003;
        sdata_i = 64'hAB; rd_i = 5'd0; pc_i = 64'h104;
        #1;
        chk("sb_req", mem_req_o, 1'b1);
        chk("sb_we", mem_we_o, 1'b1);
        chk("sb_addr", mem_addr_o, 64'h1000);
        chk("sb_wstrb", mem_wstrb_o, 8'h08);
        chk("sb_wdata", mem_wdata_o, 64'hAB000000);
        chk("sb_stall_c1", stall_o, 1'b1);
        tick();
        chk("sb_wb_valid_c1", wb_valid_o, 1'b0);
        chk("sb_stall_c2", stall_o, 1'b1);
        tick();
        mem_gnt_i = 1'b1;
        #1;
        chk("sb_stall_gnt", stall_o, 1'b0);
        tick();
        chk("sb_wb_valid", wb_valid_o, 1'b1);
        chk("sb_wb_pc", wb_pc_o, 64'h104);
        clr();

        // ---- SH 0x1002, immediate grant
        valid_i = 1'b1; store_i = 1'b1; funct3_i = 3'b001; aluout_i = 64'h1002;
        sdata_i = 64'h1234BEEF; mem_gnt_i = 1'b1;
        #1;
        chk("sh_wstrb", mem_wstrb_o, 8'h0C);
        chk("sh_wdata", mem_wdata_o, 64'h0000_1234_BEEF_0000);
        chk("sh_stall", stall_o, 1'b0);
        tick();
        chk("sh_wb_valid", wb_valid_o, 1'b1);
        clr();

        // ---- LB 0x2006, rvalid three cycles after grant
        valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'b000; aluout_i = 64'h2006;
        wen_i = 1'b1; rd_i = 5'd7; pc_i = 64'h200; exit_i = 1'b1; mem_gnt_i = 1'b1;
        mem_rdata_i = 64'h0080_0000_0000_0000;
        #1;
        chk("lb_req", mem_req_o, 1'b1);
        chk("lb_we", mem_we_o, 1'b0);
        chk("lb_wstrb", mem_wstrb_o, 8'h00);
        chk("lb_stall_gnt", stall_o, 1'b1);
        tick();
        mem_gnt_i = 1'b0;
        #1;
        chk("lb_wait_req", mem_req_o, 1'b0);
        chk("lb_wait_stall", stall_o, 1'b1);
        chk("lb_wait_wb_valid", wb_valid_o, 1'b0);
        tick(); tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("lb_rvalid_stall", stall_o, 1'b0);
        tick();
        clr();
        chk("lb_wb_valid", wb_valid_o, 1'b1);
        chk("lb_wb_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_wb_rd", wb_rd_o, 5'd7);
        chk("lb_wb_pc", wb_pc_o, 64'h200);
        chk("lb_wb_exit", wb_exit_o, 1'b1);

        // ---- LBU same address, rvalid one cycle after grant
        valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'b100; aluout_i = 64'h2006;
        wen_i = 1'b1; rd_i = 5'd8; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0080_0000_0000_0000;
        tick();
        clr();
        chk("lbu_wb_valid", wb_valid_o, 1'b1);
        chk("lbu_wb_data", wb_data_o, 64'h80);

        // ---- LW misaligned at 0x2002
        valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'b010; aluout_i = 64'h2002;
        wen_i = 1'b1; rd_i = 5'd3;
        #1;
        chk("lw_mis_req", mem_req_o, 1'b0);
        chk("lw_mis_stall", stall_o, 1'b0);
        tick();
        clr();
        chk("lw_mis_wb_valid", wb_valid_o, 1'b1);
        chk("lw_mis_flag", misalign_o, 1'b1);
        chk("lw_mis_wb_wen", wb_wen_o, 1'b0);
        tick();
        chk("lw_mis_pulse_end", misalign_o, 1'b0);

        // ---- reset while waiting for read data
        valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'b011; aluout_i = 64'h3000;
        wen_i = 1'b1; rd_i = 5'd9; pc_i = 64'h300; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw_wb_valid", wb_valid_o, 1'b0);
        chk("rstw_wb_data", wb_data_o, 64'h0);
        chk("rstw_wb_rd", wb_rd_o, 5'd0);
        chk("rstw_wb_pc", wb_pc_o, 64'h0);
        chk("rstw_req", mem_req_o, 1'b0);
        tick();
        rst = 1'b0;
        clr();
        #1;
        chk("rstw_idle_stall", stall_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_0000_0001;
        tick();
        clr();
        chk("rstw_late_rvalid", wb_valid_o, 1'b0);
        chk("rstw_late_data", wb_data_o, 64'h0);

        // ---- back-to-back LD 0x3000 then 0x3008
        valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'b011; aluout_i = 64'h3000;
        wen_i = 1'b1; rd_i = 5'd10; pc_i = 64'h400; mem_gnt_i = 1'b1;
        #1;
        chk("b2b_req1_addr", mem_addr_o, 64'h3000);
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
        #1;
        chk("b2b_rvalid1_stall", stall_o, 1'b0);
        tick();
        chk("b2b_wb_valid1", wb_valid_o, 1'b1);
        chk("b2b_wb_data1", wb_data_o, 64'h1111_2222_3333_4444);
        aluout_i = 64'h3008; rd_i = 5'd11; pc_i = 64'h404;
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; mem_rdata_i = 64'h0;
        #1;
        chk("b2b_req2", mem_req_o, 1'b1);
        chk("b2b_req2_addr", mem_addr_o, 64'h3008);
        tick();
        chk("b2b_wb_valid_gap", wb_valid_o, 1'b0);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5555_6666_7777_8888;
        tick();
        clr();
        chk("b2b_wb_valid2", wb_valid_o, 1'b1);
        chk("b2b_wb_data2", wb_data_o, 64'h5555_6666_7777_8888);
        chk("b2b_wb_rd2", wb_rd_o, 5'd11);
        chk("b2b_wb_pc2", wb_pc_o, 64'h404);
        tick();
        chk("b2b_wb_valid_end", wb_valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It takes the ALU result, load/store controls, funct3 and store data, and performs the data-memory access over a request/grant/response bus. It aligns and extends load data, and builds byte strobes for stores. It registers the result for write-back and stalls upstream while an access is outstanding.

## Interface
Parameters:
- none. Data width is fixed at 64 bits; the bus is doubleword-aligned.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  instruction from execute is valid.
- `aluout_i`  in  64  ALU result; the effective address for loads and stores.
- `load_i`, `store_i`  in  1  access type; never both set.
- `funct3_i`  in  3  access size and signedness: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- `sdata_i`  in  64  store data, taken from the low bytes.
- `wen_i`  in  1  register write enable.
- `rd_i`  in  5  destination register.
- `pc_i`  in  64  instruction PC.
- `exit_i`  in  1  exit marker.
- `stall_o`  out  1  upstream must hold all inputs stable.
- `mem_req_o`  out  1  bus request.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  64  address, computed as `{aluout_i[63:3],3'b0}`.
- `mem_wstrb_o`  out  8  byte strobes.
- `mem_wdata_o`  out  64  store data shifted to the addressed byte lane.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  64  read doubleword.
- `wb_valid_o`, `wb_wen_o`  out  1  registered outputs to write-back.
- `wb_rd_o`  out  5  registered destination register.
- `wb_data_o`, `wb_pc_o`  out  64  registered data and PC.
- `wb_exit_o`  out  1  registered exit marker.
- `misalign_o`  out  1  registered; one-cycle pulse with the faulting instruction.

## Operation
- States: IDLE and WAIT_R.
- **Non-memory instruction** (`valid_i`, with `load_i` and `store_i` both 0): completes at once; `wb_data_o` ← `aluout_i`.
- **Misaligned access**, where `off = aluout_i[2:0]`:
  - halfword with `off[0]` set, word with `off[1:0]` nonzero, or doubleword with `off` nonzero.
  - No bus request is issued. The instruction completes at once with `wb_wen_o` = 0 and `misalign_o` = 1.
- **Store in IDLE**:
  - `mem_req_o` = 1 and `mem_we_o` = 1.
  - Strobes: size-mask (1/3/F/FF hex) << `off`.
  - Write data: `sdata_i` << (8·`off`).
  - Completes in the cycle `mem_gnt_i` = 1; stays in IDLE.
- **Load in IDLE**:
  - `mem_req_o` = 1, `mem_we_o` = 0, `mem_wstrb_o` = 0.
  - On `mem_gnt_i`, capture `off`, funct3, rd, wen, pc and exit, then move to WAIT_R.
- **WAIT_R**:
  - `mem_req_o` = 0.
  - On `mem_rvalid_i`: shift `mem_rdata_i` right by 8·`off`, then sign- or zero-extend by funct3. The load completes and the state returns to IDLE.
- `stall_o` is 1 in any of these cases:
  - IDLE with a valid aligned memory op, except a store receiving `mem_gnt_i` that cycle;
  - IDLE with a load receiving `mem_gnt_i` that cycle;
  - WAIT_R while `mem_rvalid_i` = 0.
- In WAIT_R, `stall_o` drops in the `mem_rvalid_i` cycle. Execute presents its next instruction in the following cycle, and IDLE may issue it then.
- `mem_rvalid_i` outside WAIT_R is ignored. `mem_gnt_i` without a request is ignored.
- Unused funct3 value 111 is treated as LD/SD.

## Timing
- **Reset:** the state goes to IDLE and every `wb_*` output and `misalign_o` go to 0. Bus outputs are combinational and read 0 in reset.
- **Reset mid-access:** the outstanding load is dropped and any late `mem_rvalid_i` is ignored.
- **Write-back registers** load on the rising edge of a completion cycle. Otherwise `wb_valid_o` is 0 the next cycle and the other `wb_*` outputs hold.
- **Latency from `valid_i` to `wb_valid_o`:**
  - ALU op or misaligned access: 1 cycle.
  - Store: 1 + (cycles until grant).
  - Load: at least 2 cycles (grant, then rvalid no earlier than the next cycle).
- **Upstream hold rule:** while `stall_o` = 1, upstream holds all inputs. `valid_i` must not drop mid-request.

## Structure
- The shared define file holds:
  - state encodings `MEM_IDLE` / `MEM_WAIT_R`;
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`;
  - the existing `SEXT` macro, used for extension.
- One combinational sub-module, `load_align`, takes `rdata`, `off` and `funct3` and produces the extended 64-bit result. The FSM, strobe/write-data generation and write-back registers stay in `mem_stage`.

## Test plan
- **ADD passthrough:** `aluout_i`=0x1234, `wen_i`=1, `rd_i`=5 → next cycle `wb_valid_o`=1, `wb_data_o`=0x1234, `wb_rd_o`=5, no `mem_req_o`.
- **SB with delayed grant:** addr 0x1003, `sdata_i`=0xAB, grant 2 cycles late → `mem_addr_o`=0x1000, `mem_wstrb_o`=0x08, `mem_wdata_o`=0xAB000000, `stall_o` high 2 cycles, then `wb_valid_o` the cycle after grant.
- **LB sign-extend:** addr 0x2006, `mem_rdata_i`=0x00_80_0000_0000_0000, rvalid 3 cycles after grant → `wb_data_o`=0xFFFFFFFFFFFFFF80. The same case with LBU → 0x80.
- **LW misaligned:** addr 0x2002 → no request, `misalign_o`=1, `wb_wen_o`=0.
- **Reset in WAIT_R:** assert `rst` after grant, then pulse rvalid → no `wb_valid_o`, state IDLE, all `wb_*` outputs 0.
- **Back-to-back loads:** LD 0x3000 then LD 0x3008 with rvalid 1 cycle after each grant → two `wb_valid_o` pulses, data in order, second request issued the cycle after the first rvalid.
